// File: rtl/ddr_axi_pattern_tester.sv
`default_nettype none
// ============================================================================
// Module   : ddr_axi_pattern_tester
// Brief    : AXI4 burst master that writes a selectable pattern over a DDR
//            region, reads it back and reports beat mismatches.
// Revision : 1.0 - initial release
// ============================================================================
module ddr_axi_pattern_tester #(
    parameter int          ADDR_W     = 32,
    parameter int          DATA_W     = 64,
    parameter int          BURST_LEN  = 16,
    parameter int          NUM_BURSTS = 64,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          ERRCNT_W   = 16
) (
    input  logic                ACLK,
    input  logic                ARESETN,
    input  logic                INIT_AXI_TXN,
    input  logic [1:0]          CFG_MODE,
    input  logic [31:0]         CFG_SEED,
    output logic                TXN_DONE,
    output logic                ERROR,
    output logic [ERRCNT_W-1:0] ERR_COUNT,
    output logic [ADDR_W-1:0]   FIRST_ERR_ADDR,
    output logic                BUSY,
    output logic [ADDR_W-1:0]   M_AXI_AWADDR,
    output logic [7:0]          M_AXI_AWLEN,
    output logic [2:0]          M_AXI_AWSIZE,
    output logic [1:0]          M_AXI_AWBURST,
    output logic                M_AXI_AWVALID,
    input  logic                M_AXI_AWREADY,
    output logic [DATA_W-1:0]   M_AXI_WDATA,
    output logic [DATA_W/8-1:0] M_AXI_WSTRB,
    output logic                M_AXI_WLAST,
    output logic                M_AXI_WVALID,
    input  logic                M_AXI_WREADY,
    input  logic [1:0]          M_AXI_BRESP,
    input  logic                M_AXI_BVALID,
    output logic                M_AXI_BREADY,
    output logic [ADDR_W-1:0]   M_AXI_ARADDR,
    output logic [7:0]          M_AXI_ARLEN,
    output logic [2:0]          M_AXI_ARSIZE,
    output logic [1:0]          M_AXI_ARBURST,
    output logic                M_AXI_ARVALID,
    input  logic                M_AXI_ARREADY,
    input  logic [DATA_W-1:0]   M_AXI_RDATA,
    input  logic [1:0]          M_AXI_RRESP,
    input  logic                M_AXI_RLAST,
    input  logic                M_AXI_RVALID,
    output logic                M_AXI_RREADY
);

    localparam int          BYTES       = DATA_W / 8;
    localparam int          BURST_BYTES = BURST_LEN * BYTES;
    localparam int          LANES       = DATA_W / 32;
    localparam logic [31:0] LFSR_MASK   = 32'h8020_0003;

    generate
        if (BURST_BYTES > 4096) begin : g_burst_too_big
            $error("ddr_axi_pattern_tester: burst exceeds 4 KB boundary");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_ADDR = 3'd1,
        S_WR_DATA = 3'd2,
        S_WR_RESP = 3'd3,
        S_RD_ADDR = 3'd4,
        S_RD_DATA = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_init_d;
    logic [1:0]          r_mode;
    logic [31:0]         r_seed;
    logic [31:0]         r_k;
    logic [31:0]         r_lfsr;
    logic [31:0]         r_burst;
    logic [31:0]         r_beat;
    logic                r_done;
    logic                r_error;
    logic [ERRCNT_W-1:0] r_err_cnt;
    logic [ADDR_W-1:0]   r_first_addr;

    logic                w_start;
    logic                w_awvalid, w_wvalid, w_bready, w_arvalid, w_rready;
    logic                w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
    logic                w_last_beat, w_last_burst;
    logic [ADDR_W-1:0]   w_burst_addr;
    logic [ADDR_W-1:0]   w_beat_addr;
    logic [31:0]         w_lane;
    logic [31:0]         w_lfsr_next;
    logic [31:0]         w_lfsr_init;
    logic [DATA_W-1:0]   w_data;
    logic                w_err_evt;
    logic [ADDR_W-1:0]   w_err_addr;

    assign w_start      = ((r_state == S_IDLE) || (r_state == S_DONE)) && INIT_AXI_TXN && !r_init_d;
    assign w_aw_hs      = w_awvalid && M_AXI_AWREADY;
    assign w_w_hs       = w_wvalid  && M_AXI_WREADY;
    assign w_b_hs       = w_bready  && M_AXI_BVALID;
    assign w_ar_hs      = w_arvalid && M_AXI_ARREADY;
    assign w_r_hs       = w_rready  && M_AXI_RVALID;
    assign w_last_beat  = (r_beat  == 32'(BURST_LEN - 1));
    assign w_last_burst = (r_burst == 32'(NUM_BURSTS - 1));

    // Bursts are contiguous, so the global beat index alone locates any beat.
    assign w_burst_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(r_burst) * ADDR_W'(BURST_BYTES);
    assign w_beat_addr  = ADDR_W'(BASE_ADDR) + ADDR_W'(r_k) * ADDR_W'(BYTES);

    assign w_lfsr_next = r_lfsr[0] ? ((r_lfsr >> 1) ^ LFSR_MASK) : (r_lfsr >> 1);
    assign w_lfsr_init = (r_seed == 32'h0) ? 32'h1 : r_seed;

    always_comb begin
        w_lane = r_seed + r_k;
        case (r_mode)
            2'd1:    w_lane = r_lfsr;
            2'd2:    w_lane = 32'h1 << r_k[4:0];
            2'd3:    w_lane = 32'(w_beat_addr);
            default: w_lane = r_seed + r_k;
        endcase
    end

    assign w_data = {LANES{w_lane}};

    always_comb begin
        w_err_evt  = 1'b0;
        w_err_addr = w_beat_addr;
        if (w_b_hs && (M_AXI_BRESP != 2'b00)) begin
            w_err_evt  = 1'b1;
            w_err_addr = w_burst_addr;
        end
        if (w_r_hs && ((M_AXI_RDATA != w_data) || (M_AXI_RRESP != 2'b00) ||
                       (M_AXI_RLAST != w_last_beat))) begin
            w_err_evt = 1'b1;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_awvalid = 1'b0;
        w_wvalid  = 1'b0;
        w_bready  = 1'b0;
        w_arvalid = 1'b0;
        w_rready  = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_start) w_next = S_WR_ADDR;
            end
            S_WR_ADDR: begin
                w_awvalid = 1'b1;
                if (M_AXI_AWREADY) w_next = S_WR_DATA;
            end
            S_WR_DATA: begin
                w_wvalid = 1'b1;
                if (M_AXI_WREADY && w_last_beat) w_next = S_WR_RESP;
            end
            S_WR_RESP: begin
                w_bready = 1'b1;
                if (M_AXI_BVALID) w_next = w_last_burst ? S_RD_ADDR : S_WR_ADDR;
            end
            S_RD_ADDR: begin
                w_arvalid = 1'b1;
                if (M_AXI_ARREADY) w_next = S_RD_DATA;
            end
            S_RD_DATA: begin
                w_rready = 1'b1;
                if (M_AXI_RVALID && w_last_beat) w_next = w_last_burst ? S_DONE : S_RD_ADDR;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_init_d     <= 1'b0;
            r_mode       <= 2'd0;
            r_seed       <= 32'h0;
            r_k          <= 32'h0;
            r_lfsr       <= 32'h1;
            r_burst      <= 32'h0;
            r_beat       <= 32'h0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_err_cnt    <= '0;
            r_first_addr <= '0;
        end else begin
            r_init_d <= INIT_AXI_TXN;
            if (w_start) begin
                r_mode       <= CFG_MODE;
                r_seed       <= CFG_SEED;
                r_lfsr       <= (CFG_SEED == 32'h0) ? 32'h1 : CFG_SEED;
                r_k          <= 32'h0;
                r_burst      <= 32'h0;
                r_beat       <= 32'h0;
                r_done       <= 1'b0;
                r_error      <= 1'b0;
                r_err_cnt    <= '0;
                r_first_addr <= '0;
            end
            if (w_w_hs || w_r_hs) begin
                r_k    <= r_k + 32'd1;
                r_lfsr <= w_lfsr_next;
                r_beat <= w_last_beat ? 32'h0 : r_beat + 32'd1;
            end
            // Rewinding here makes the read expectation replay the write stream.
            if (w_b_hs) begin
                if (w_last_burst) begin
                    r_burst <= 32'h0;
                    r_k     <= 32'h0;
                    r_lfsr  <= w_lfsr_init;
                end else begin
                    r_burst <= r_burst + 32'd1;
                end
            end
            if (w_r_hs && w_last_beat) begin
                if (w_last_burst) begin
                    r_burst <= 32'h0;
                    r_done  <= 1'b1;
                end else begin
                    r_burst <= r_burst + 32'd1;
                end
            end
            if (w_err_evt) begin
                r_error <= 1'b1;
                if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
                if (!r_error) r_first_addr <= w_err_addr;
            end
        end
    end

    assign TXN_DONE       = r_done;
    assign ERROR          = r_error;
    assign ERR_COUNT      = r_err_cnt;
    assign FIRST_ERR_ADDR = r_first_addr;
    assign BUSY           = (r_state != S_IDLE) && (r_state != S_DONE);

    assign M_AXI_AWADDR   = w_burst_addr;
    assign M_AXI_AWLEN    = 8'(BURST_LEN - 1);
    assign M_AXI_AWSIZE   = 3'($clog2(BYTES));
    assign M_AXI_AWBURST  = 2'b01;
    assign M_AXI_AWVALID  = w_awvalid;
    assign M_AXI_WDATA    = w_data;
    assign M_AXI_WSTRB    = '1;
    assign M_AXI_WLAST    = w_last_beat;
    assign M_AXI_WVALID   = w_wvalid;
    assign M_AXI_BREADY   = w_bready;
    assign M_AXI_ARADDR   = w_burst_addr;
    assign M_AXI_ARLEN    = 8'(BURST_LEN - 1);
    assign M_AXI_ARSIZE   = 3'($clog2(BYTES));
    assign M_AXI_ARBURST  = 2'b01;
    assign M_AXI_ARVALID  = w_arvalid;
    assign M_AXI_RREADY   = w_rready;

endmodule
`default_nettype wire

// File: tb/tb_ddr_axi_pattern_tester.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddr_axi_pattern_tester
// Brief    : Scoreboard bench with a memory-backed AXI slave and fault hooks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ddr_axi_pattern_tester;

    localparam int          DW   = 64;
    localparam int          BL   = 8;
    localparam int          NB   = 4;
    localparam int          EW   = 4;
    localparam logic [31:0] BASE = 32'h0000_1000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          init;
    logic [1:0]    cfg_mode;
    logic [31:0]   cfg_seed;
    logic          txn_done, error, busy;
    logic [EW-1:0] err_count;
    logic [31:0]   first_err;
    logic [31:0]   awaddr, araddr;
    logic [7:0]    awlen, arlen;
    logic [2:0]    awsize, arsize;
    logic [1:0]    awburst, arburst;
    logic          awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic          arvalid, arready, rvalid, rready, rlast;
    logic [DW-1:0] wdata, rdata;
    logic [7:0]    wstrb;
    logic [1:0]    bresp, rresp;

    always #5 clk = ~clk;

    ddr_axi_pattern_tester #(
        .ADDR_W(32), .DATA_W(DW), .BURST_LEN(BL), .NUM_BURSTS(NB),
        .BASE_ADDR(BASE), .ERRCNT_W(EW)
    ) dut (
        .ACLK(clk), .ARESETN(rst_n), .INIT_AXI_TXN(init),
        .CFG_MODE(cfg_mode), .CFG_SEED(cfg_seed),
        .TXN_DONE(txn_done), .ERROR(error), .ERR_COUNT(err_count),
        .FIRST_ERR_ADDR(first_err), .BUSY(busy),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize),
        .M_AXI_AWBURST(awburst), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast),
        .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize),
        .M_AXI_ARBURST(arburst), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RLAST(rlast),
        .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0]   exp_aw[$];
    logic [31:0]   exp_ar[$];
    logic [DW-1:0] exp_w[$];
    logic [DW-1:0] mem [logic [31:0]];

    // Slave fault hooks and backpressure enable.
    bit bp;
    int bad_b_burst, cor_burst, cor_beat, rr_burst, rr_beat;
    bit cor_all;

    bit            b_fire, r_fire, r_active, b_pend, aw_hold, w_hold, ar_hold;
    logic [31:0]   aw_held, ar_held, wr_addr, rd_addr;
    logic [DW-1:0] w_held;
    logic          w_held_last;
    int            wr_beat, rd_beat, rd_burst, aw_cnt, ar_cnt, b_cnt;

    task automatic check_val(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lane(input int m, input logic [31:0] s, input int k);
        logic [31:0] v;
        case (m)
            0: v = s + 32'(k);
            1: begin
                v = (s == 32'h0) ? 32'h1 : s;
                for (int i = 0; i < k; i++) v = v[0] ? ((v >> 1) ^ 32'h8020_0003) : (v >> 1);
            end
            2: v = 32'h1 << (k % 32);
            default: v = BASE + 32'(k * 8);
        endcase
        return v;
    endfunction

    function automatic logic pick();
        return !bp || ($urandom_range(0, 2) == 0);
    endfunction

    task automatic slave_clear();
        awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0;
        rvalid = 0; rdata = '0; rresp = 0; rlast = 0;
        b_fire = 0; r_fire = 0; r_active = 0; b_pend = 0;
        aw_hold = 0; w_hold = 0; ar_hold = 0; wr_beat = 0; rd_beat = 0;
    endtask

    // Memory-backed slave; a handshake decided at a negedge completes on the next posedge.
    initial begin
        slave_clear();
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                slave_clear();
                continue;
            end
            if (b_fire) bvalid = 0;
            if (b_pend && !bvalid) begin
                bvalid = 1;
                bresp  = (b_cnt == bad_b_burst) ? 2'b10 : 2'b00;
                b_pend = 0;
                b_cnt++;
            end
            if (r_fire) begin
                if (rd_beat == BL - 1 && rd_burst == NB - 1)
                    check_val("done_latency", {txn_done, busy}, 2'b10);
                rd_beat++;
                if (rd_beat == BL) r_active = 0;
            end
            if (r_active && (rvalid || pick())) begin
                logic [31:0] a;
                a = rd_addr + 32'(rd_beat * 8);
                rdata = (mem.exists(a) ? mem[a] : '0) ^
                        ((cor_all || (rd_burst == cor_burst && rd_beat == cor_beat)) ? 64'h1 : 64'h0);
                rresp  = (rd_burst == rr_burst && rd_beat == rr_beat) ? 2'b10 : 2'b00;
                rlast  = (rd_beat == BL - 1);
                rvalid = 1;
            end else begin
                rvalid = 0;
            end
            if (aw_hold) check_val("aw_stable", {awvalid, awaddr}, {1'b1, aw_held});
            awready = pick();
            if (awvalid && awready) begin
                if (exp_aw.size() == 0) check_val("aw_extra", 1, 0);
                else check_val("awaddr", awaddr, exp_aw.pop_front());
                check_val("aw_attr", {awlen, awsize, awburst}, {8'd7, 3'd3, 2'b01});
                wr_addr = awaddr; wr_beat = 0; aw_cnt++;
            end
            aw_hold = awvalid && !awready; aw_held = awaddr;
            if (w_hold) check_val("w_stable", {wvalid, wlast, wdata}, {1'b1, w_held_last, w_held});
            wready = pick();
            if (wvalid && wready) begin
                if (exp_w.size() == 0) check_val("w_extra", 1, 0);
                else check_val("wdata", wdata, exp_w.pop_front());
                check_val("wlast_strb", {wlast, wstrb}, {(wr_beat == BL - 1), 8'hFF});
                mem[wr_addr + 32'(wr_beat * 8)] = wdata;
                wr_beat++;
                if (wr_beat == BL) begin b_pend = 1; wr_beat = 0; end
            end
            w_hold = wvalid && !wready; w_held = wdata; w_held_last = wlast;
            if (ar_hold) check_val("ar_stable", {arvalid, araddr}, {1'b1, ar_held});
            arready = pick();
            if (arvalid && arready) begin
                if (exp_ar.size() == 0) check_val("ar_extra", 1, 0);
                else check_val("araddr", araddr, exp_ar.pop_front());
                check_val("ar_attr", {arlen, arsize, arburst}, {8'd7, 3'd3, 2'b01});
                rd_addr = araddr; rd_beat = 0; rd_burst = ar_cnt; ar_cnt++; r_active = 1;
            end
            ar_hold = arvalid && !arready; ar_held = araddr;
            b_fire = bvalid && bready;
            r_fire = rvalid && rready;
        end
    end

    task automatic clear_faults();
        bp = 0; bad_b_burst = -1; cor_burst = -1; cor_beat = -1;
        rr_burst = -1; rr_beat = -1; cor_all = 0;
    endtask

    task automatic start_pass(input int m, input logic [31:0] s);
        aw_cnt = 0; ar_cnt = 0; b_cnt = 0;
        for (int b = 0; b < NB; b++) begin
            exp_aw.push_back(BASE + 32'(b * BL * 8));
            exp_ar.push_back(BASE + 32'(b * BL * 8));
        end
        for (int k = 0; k < NB * BL; k++) exp_w.push_back({2{lane(m, s, k)}});
        cfg_mode = 2'(m); cfg_seed = s;
        init = 1;
        @(negedge clk);
        init = 0;
        check_val("start_clear", {busy, txn_done, error, err_count}, {3'b100, 4'h0});
        cfg_mode = ~cfg_mode; cfg_seed = ~cfg_seed;
    endtask

    task automatic finish_pass(input bit e, input int cnt, input logic [31:0] fa);
        int n;
        n = 0;
        while (!txn_done && n < 5000) begin @(negedge clk); n++; end
        check_val("pass_done", {txn_done, busy}, 2'b10);
        check_val("error", error, e);
        check_val("err_count", err_count, cnt);
        check_val("first_err", first_err, fa);
        check_val("queues_left", exp_aw.size() + exp_ar.size() + exp_w.size(), 0);
    endtask

    initial begin
        int n;
        rst_n = 0; init = 0; cfg_mode = 0; cfg_seed = 0;
        clear_faults();
        repeat (3) @(negedge clk);
        check_val("rst_outs", {awvalid, wvalid, bready, arvalid, rready, busy, txn_done, error}, 8'h00);
        check_val("rst_regs", {err_count, first_err}, 36'h0);
        rst_n = 1;
        repeat (2) @(negedge clk);

        start_pass(0, 32'h0);          finish_pass(0, 0, 32'h0);
        bp = 1;
        start_pass(1, 32'h0000_ACE1);  finish_pass(0, 0, 32'h0);
        start_pass(1, 32'h0);          finish_pass(0, 0, 32'h0);
        start_pass(2, 32'h1234_5678);  finish_pass(0, 0, 32'h0);
        clear_faults();

        cor_burst = 2; cor_beat = 5;
        start_pass(3, 32'h0);          finish_pass(1, 1, BASE + 32'hA8);
        clear_faults();

        bad_b_burst = 0; rr_burst = 3; rr_beat = 2;
        start_pass(2, 32'h0);          finish_pass(1, 2, BASE);
        clear_faults();

        cor_all = 1;
        start_pass(0, 32'h55);         finish_pass(1, 15, BASE);
        clear_faults();

        cor_burst = 0; cor_beat = 0;
        start_pass(0, 32'h7);
        n = 0;
        while (!wvalid && n < 200) begin @(negedge clk); n++; end
        init = 1;
        @(negedge clk);
        init = 0;
        n = 0;
        while (!(rready && error) && n < 3000) begin @(negedge clk); n++; end
        check_val("mid_init_ignored", {rready, error, 32'(aw_cnt)}, {2'b11, 32'd4});
        #2 rst_n = 0;
        #1;
        check_val("async_rst", {awvalid, wvalid, bready, arvalid, rready, busy, txn_done, error}, 8'h00);
        check_val("async_rst_cnt", err_count, 0);
        exp_aw.delete(); exp_ar.delete(); exp_w.delete();
        clear_faults();
        repeat (2) @(negedge clk);
        rst_n = 1;
        repeat (2) @(negedge clk);
        start_pass(0, 32'h5);          finish_pass(0, 0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
